// File: rtl/gpu_frame_ctrl.sv
// rtl/gpu_frame_ctrl.sv - per-frame button/time configuration offer to gpu_core
module gpu_frame_ctrl #(
  parameter int DB_CYCLES  = 250000,
  parameter int TIME_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        cfg_ready,
  output logic        cfg_valid,
  output logic [3:0]  cfg_buttons,
  output logic [7:0]  cfg_time,
  output logic        frame_start,
  output logic [31:0] frame_timer,
  output logic [7:0]  dropped_frames
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state, state_next;

  // bit order: 0=up, 1=down, 2=left, 3=right
  logic [3:0]         raw;
  logic [3:0]         sync1, sync2, db;
  logic [3:0][CW-1:0] db_cnt;
  logic [3:0]         delta;
  logic [3:0]         acc;
  logic               vsync_prev;
  logic               frame_event;
  logic               load, drop;
  logic [7:0]         slow_time;

  assign raw         = {btn_r, btn_l, btn_d, btn_u};
  assign frame_event = vsync_in & ~vsync_prev;
  assign slow_time   = frame_timer[TIME_SHIFT+7:TIME_SHIFT];

  // two-flop synchronizers and per-button debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // signed button delta folded into 4 bits; opposing buttons cancel
  always_comb begin
    delta = 4'd0;
    if (db[0]) delta = delta + 4'd1;
    if (db[1]) delta = delta - 4'd1;
    if (db[2]) delta = delta - 4'd4;
    if (db[3]) delta = delta + 4'd4;
  end

  // rising-edge frame detect; counters advance as frame_start is raised
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev  <= 1'b1;
      frame_start <= 1'b0;
      frame_timer <= '0;
      acc         <= '0;
    end else begin
      vsync_prev  <= vsync_in;
      frame_start <= frame_event;
      if (frame_event) begin
        frame_timer <= frame_timer + 32'd1;
        acc         <= acc + delta;
      end
    end
  end

  // offer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state, payload load and overrun detection
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    cfg_valid  = (state == ISSUE);
    case (state)
      IDLE, DONE: begin
        if (frame_start) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
      ISSUE: begin
        if (frame_start) begin
          load = 1'b1;
          drop = ~cfg_ready;
        end else if (cfg_ready) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // payload registers and saturating overrun counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_buttons    <= '0;
      cfg_time       <= '0;
      dropped_frames <= '0;
    end else begin
      if (load) begin
        cfg_buttons <= acc;
        cfg_time    <= slow_time;
      end
      if (drop && dropped_frames != 8'hFF) begin
        dropped_frames <= dropped_frames + 8'd1;
      end
    end
  end

endmodule
